// File: rtl/scr1_ahb_sram_slv.sv
// AHB-Lite responder for a single-port synchronous SRAM with a one-entry delayed-write buffer.
// Define SCR1_AHB_SLV_RDATA_REG_EN to register read data (one wait state per read).
module scr1_ahb_sram_slv #(
  parameter int          SCR1_SLV_AWIDTH = 14,
  parameter logic [31:0] SCR1_SLV_BASE   = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hsel,
  input  logic [1:0]                 htrans,
  input  logic [31:0]                haddr,
  input  logic                       hwrite,
  input  logic [2:0]                 hsize,
  input  logic [31:0]                hwdata,
  input  logic                       hready,
  output logic                       hreadyout,
  output logic                       hresp,
  output logic [31:0]                hrdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [SCR1_SLV_AWIDTH-1:0] mem_addr,
  output logic [3:0]                 mem_be,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata
);

  localparam int AW = SCR1_SLV_AWIDTH;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;
`ifdef SCR1_AHB_SLV_RDATA_REG_EN
  localparam logic [2:0] ST_RD2  = 3'd5;
`endif

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic          wb_vld_q, wb_vld_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [3:0]    wb_be_q, wb_be_d;
  logic [31:0]   wb_data_q, wb_data_d;

  logic          addr_err, rd_pend, stall;
  logic          accept, rd_acc, wr_acc, err_acc;
  logic          wr_done, commit, fwd;
  logic [31:0]   rd_merged;

  function automatic logic [3:0] size_be(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    size_be = 4'b0001 << a;
      3'd1:    size_be = 4'b0011 << a;
      default: size_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] base, input logic [31:0] upd,
                                             input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      byte_merge[8*b +: 8] = be[b] ? upd[8*b +: 8] : base[8*b +: 8];
  endfunction

  assign addr_err = (haddr[31:AW+2] != SCR1_SLV_BASE[31:AW+2]) | (hsize > 3'd2)
                  | ((hsize == 3'd1) & haddr[0]) | ((hsize == 3'd2) & (|haddr[1:0]));

  // Stall detection must not look at hready: on a single-slave bus it is hreadyout itself.
  assign rd_pend = hsel & htrans[1] & ~addr_err & ~hwrite;
  assign stall   = (state_q == ST_WR) & wb_vld_q & rd_pend;

  always_comb begin
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state_q)
      ST_ERR1: begin hreadyout = 1'b0; hresp = 1'b1; end
      ST_ERR2: hresp = 1'b1;
      ST_WR:   hreadyout = ~stall;
`ifdef SCR1_AHB_SLV_RDATA_REG_EN
      ST_RD:   hreadyout = 1'b0;
`endif
      default: ;
    endcase
  end

  assign accept  = hsel & htrans[1] & hready & hreadyout;
  assign rd_acc  = accept & ~addr_err & ~hwrite;
  assign wr_acc  = accept & ~addr_err & hwrite;
  assign err_acc = accept & addr_err;

  assign wr_done = (state_q == ST_WR) & hreadyout;
  assign commit  = wb_vld_q & ~rd_acc;

  // A new read owns the SRAM port; otherwise the buffered write drains.
  assign mem_req   = rd_acc | commit;
  assign mem_we    = commit;
  assign mem_addr  = rd_acc ? haddr[AW+1:2] : wb_addr_q;
  assign mem_be    = rd_acc ? 4'b1111 : wb_be_q;
  assign mem_wdata = wb_data_q;

  assign fwd       = wb_vld_q & (wb_addr_q == addr_q);
  assign rd_merged = byte_merge(mem_rdata, wb_data_q, fwd ? wb_be_q : 4'b0000);

  always_comb begin
    state_d = state_q;
    if (hreadyout) begin
      if (err_acc)     state_d = ST_ERR1;
      else if (rd_acc) state_d = ST_RD;
      else if (wr_acc) state_d = ST_WR;
      else             state_d = ST_IDLE;
    end else if (state_q == ST_ERR1) begin
      state_d = ST_ERR2;
`ifdef SCR1_AHB_SLV_RDATA_REG_EN
    end else if (state_q == ST_RD) begin
      state_d = ST_RD2;
`endif
    end
  end

  always_comb begin
    addr_d    = accept ? haddr[AW+1:2] : addr_q;
    be_d      = accept ? size_be(hsize, haddr[1:0]) : be_q;
    wb_vld_d  = wr_done ? 1'b1 : (commit ? 1'b0 : wb_vld_q);
    wb_addr_d = wr_done ? addr_q : wb_addr_q;
    wb_be_d   = wr_done ? be_q : wb_be_q;
    wb_data_d = wr_done ? hwdata : wb_data_q;
  end

`ifdef SCR1_AHB_SLV_RDATA_REG_EN
  logic [31:0] rdata_q, rdata_d;

  assign rdata_d = (state_q == ST_RD) ? rd_merged : rdata_q;
  assign hrdata  = (state_q == ST_RD2) ? rdata_q : 32'h0;

  always_ff @(posedge clk) rdata_q <= rdata_d;
`else
  assign hrdata = (state_q == ST_RD) ? rd_merged : 32'h0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      wb_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wb_vld_q <= wb_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    be_q      <= be_d;
    wb_addr_q <= wb_addr_d;
    wb_be_q   <= wb_be_d;
    wb_data_q <= wb_data_d;
  end

endmodule

// File: tb/tb_scr1_ahb_sram_slv.sv
// Table-driven bench for scr1_ahb_sram_slv with a behavioural SRAM and hand-written reset sequence.
module tb_scr1_ahb_sram_slv;

  logic        clk, rst_n;
  logic        hsel, hwrite, hready, hreadyout, hresp;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, hrdata;
  logic        mem_req, mem_we;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  scr1_ahb_sram_slv #(.SCR1_SLV_AWIDTH(14), .SCR1_SLV_BASE(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .hsel(hsel), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign hready = hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] sram [0:(1<<14)-1];

  function automatic logic [31:0] bmerge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      bmerge[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
  endfunction

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) sram[mem_addr] <= bmerge(sram[mem_addr], mem_wdata, mem_be);
      else        mem_rdata <= sram[mem_addr];
    end
  end

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        rdy;
    logic        resp;
    logic        ck_rd;
    logic [31:0] rd;
    logic        req;
    logic        we;
    logic [13:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwd;
  } vec_t;

  function automatic vec_t v(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                             input logic wr, input logic [2:0] size, input logic [31:0] wdata,
                             input logic rdy, input logic resp, input logic ck_rd,
                             input logic [31:0] rd, input logic req, input logic we,
                             input logic [13:0] maddr, input logic [3:0] be,
                             input logic [31:0] mwd);
    v = '{sel, trans, addr, wr, size, wdata, rdy, resp, ck_rd, rd, req, we, maddr, be, mwd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                       input logic wr, input logic [2:0] sz, input logic [31:0] wd);
    hsel = sel; htrans = tr; haddr = a; hwrite = wr; hsize = sz; hwdata = wd;
  endtask

  localparam logic [1:0] NS = 2'b10, ID = 2'b00, BZ = 2'b01;
  localparam int NV = 30;
  vec_t tbl [NV];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Word write / read back
    tbl[0]  = v(1, NS, 32'h10, 1, 2, 0,            1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[1]  = v(0, ID, 0,      0, 0, 32'hDEADBEEF, 1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[2]  = v(0, ID, 0,      0, 0, 0,            1, 0, 0, 0,            1, 1, 14'h4, 4'hF,  32'hDEADBEEF);
    tbl[3]  = v(1, NS, 32'h10, 0, 2, 0,            1, 0, 0, 0,            1, 0, 14'h4, 0,     0);
    tbl[4]  = v(0, ID, 0,      0, 0, 0,            1, 0, 1, 32'hDEADBEEF, 0, 0, 0,     0,     0);
    // Write then immediate read: forwarded, commit after the read
    tbl[5]  = v(1, NS, 32'h20, 1, 2, 0,            1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[6]  = v(1, NS, 32'h20, 0, 2, 32'h11223344, 1, 0, 0, 0,            1, 0, 14'h8, 0,     0);
    tbl[7]  = v(0, ID, 0,      0, 0, 0,            1, 0, 1, 32'h11223344, 1, 1, 14'h8, 4'hF,  32'h11223344);
    tbl[8]  = v(0, ID, 0,      0, 0, 0,            1, 0, 1, 0,            0, 0, 0,     0,     0);
    // Byte write then word read: partial forwarding
    tbl[9]  = v(1, NS, 32'h21, 1, 0, 0,            1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[10] = v(0, ID, 0,      0, 0, 32'h0000AB00, 1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[11] = v(1, NS, 32'h20, 0, 2, 0,            1, 0, 0, 0,            1, 0, 14'h8, 0,     0);
    tbl[12] = v(0, ID, 0,      0, 0, 0,            1, 0, 1, 32'h1122AB44, 1, 1, 14'h8, 4'h2,  32'h0000AB00);
    // Write, write, read: one stall cycle in the second WR
    tbl[13] = v(1, NS, 32'h30, 1, 2, 0,            1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[14] = v(1, NS, 32'h34, 1, 2, 32'h30303030, 1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[15] = v(1, NS, 32'h30, 0, 2, 32'h34343434, 0, 0, 0, 0,            1, 1, 14'hC, 4'hF,  32'h30303030);
    tbl[16] = v(1, NS, 32'h30, 0, 2, 32'h34343434, 1, 0, 0, 0,            1, 0, 14'hC, 0,     0);
    tbl[17] = v(0, ID, 0,      0, 0, 0,            1, 0, 1, 32'h30303030, 1, 1, 14'hD, 4'hF,  32'h34343434);
    // Out-of-window read
    tbl[18] = v(1, NS, 32'h0001_0000, 0, 2, 0,     1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[19] = v(0, ID, 0,      0, 0, 0,            0, 1, 0, 0,            0, 0, 0,     0,     0);
    tbl[20] = v(0, ID, 0,      0, 0, 0,            1, 1, 0, 0,            0, 0, 0,     0,     0);
    // Misaligned halfword; read held through ERR1 is only taken in ERR2
    tbl[21] = v(1, NS, 32'h3,  0, 1, 0,            1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[22] = v(1, NS, 32'h10, 0, 2, 0,            0, 1, 0, 0,            0, 0, 0,     0,     0);
    tbl[23] = v(1, NS, 32'h10, 0, 2, 0,            1, 1, 0, 0,            1, 0, 14'h4, 0,     0);
    tbl[24] = v(0, ID, 0,      0, 0, 0,            1, 0, 1, 32'hDEADBEEF, 0, 0, 0,     0,     0);
    // Illegal size, then BUSY while selected
    tbl[25] = v(1, NS, 32'h40, 1, 3, 0,            1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[26] = v(0, ID, 0,      0, 0, 32'h99999999, 0, 1, 0, 0,            0, 0, 0,     0,     0);
    tbl[27] = v(0, ID, 0,      0, 0, 0,            1, 1, 0, 0,            0, 0, 0,     0,     0);
    tbl[28] = v(1, BZ, 32'h10, 0, 2, 0,            1, 0, 0, 0,            0, 0, 0,     0,     0);
    tbl[29] = v(0, ID, 0,      0, 0, 0,            1, 0, 1, 0,            0, 0, 0,     0,     0);

    rst_n = 1'b0;
    drive(0, ID, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset hreadyout", {31'd0, hreadyout}, 32'd1);
    chk("reset hresp", {31'd0, hresp}, 32'd0);
    chk("reset hrdata", hrdata, 32'd0);
    chk("reset mem_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].sel, tbl[i].trans, tbl[i].addr, tbl[i].wr, tbl[i].size, tbl[i].wdata);
      #3;
      chk($sformatf("row%0d hreadyout", i), {31'd0, hreadyout}, {31'd0, tbl[i].rdy});
      chk($sformatf("row%0d hresp", i), {31'd0, hresp}, {31'd0, tbl[i].resp});
      chk($sformatf("row%0d mem_req", i), {31'd0, mem_req}, {31'd0, tbl[i].req});
      if (tbl[i].ck_rd) chk($sformatf("row%0d hrdata", i), hrdata, tbl[i].rd);
      if (tbl[i].req) begin
        chk($sformatf("row%0d mem_we", i), {31'd0, mem_we}, {31'd0, tbl[i].we});
        chk($sformatf("row%0d mem_addr", i), {18'd0, mem_addr}, {18'd0, tbl[i].maddr});
        if (tbl[i].we) begin
          chk($sformatf("row%0d mem_be", i), {28'd0, mem_be}, {28'd0, tbl[i].be});
          chk($sformatf("row%0d mem_wdata", i), mem_wdata, tbl[i].mwd);
        end
      end
    end

    // Reset with a write still in the buffer: it must be dropped
    @(posedge clk); #1; drive(1, NS, 32'h50, 1, 2, 0);
    #3 chk("rs0 mem_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1; drive(0, ID, 0, 0, 0, 32'h55AA55AA);
    @(posedge clk); #1; drive(0, ID, 0, 0, 0, 0);
    #3 chk("rs2 commit we", {31'd0, mem_req & mem_we}, 32'd1);
    chk("rs2 commit addr", {18'd0, mem_addr}, 32'h14);
    @(posedge clk); #1; drive(1, NS, 32'h50, 1, 2, 0);
    @(posedge clk); #1; drive(0, ID, 0, 0, 0, 32'hCAFEF00D);
    @(posedge clk); #1; drive(0, ID, 0, 0, 0, 0);
    #2 chk("rs5 pending commit", {31'd0, mem_req & mem_we}, 32'd1);
    chk("rs5 pending data", mem_wdata, 32'hCAFEF00D);
    #1 rst_n = 1'b0;
    #1;
    chk("rs hreadyout in reset", {31'd0, hreadyout}, 32'd1);
    chk("rs hresp in reset", {31'd0, hresp}, 32'd0);
    chk("rs mem_req in reset", {31'd0, mem_req}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rs sram untouched", sram[14'h14], 32'h55AA55AA);
    @(posedge clk); #1; drive(1, NS, 32'h50, 0, 2, 0);
    #3 chk("rs read mem_req", {31'd0, mem_req & ~mem_we}, 32'd1);
    @(posedge clk); #1; drive(0, ID, 0, 0, 0, 0);
    #3 chk("rs read hrdata", hrdata, 32'h55AA55AA);
    chk("rs read no commit", {31'd0, mem_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
